// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the GRF write-back writer: source select,
// buffered long-latency result entry, and a register one-hot helper.
package grf_wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NREGS    = 32;
    localparam int         WB_DW    = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_W    = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_t;

    typedef struct packed {
        logic [4:0]       wa;
        logic [WB_DW-1:0] data;
        logic [WB_DW-1:0] pc;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [4:0] wa);
        return NREGS'(1) << wa;
    endfunction

endpackage

// File: rtl/grf_wb_writer_wb_fifo.sv
// Small synchronous FIFO of write-back entries; pointers wrap modulo DEPTH
// (DEPTH is a power of two), count saturates at DEPTH and never underflows.
module wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  wb_entry_t       push_data_i,
    input  logic            pop_i,
    output wb_entry_t       head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CW-1:0]   count_o
);

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push_eff, pop_eff;

    assign full_o   = (cnt_q == CW'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign count_o  = cnt_q;
    assign head_o   = mem_q[rd_ptr_q];

    // A push while full is dropped; the writer never requests one.
    assign push_eff = push_i & ~full_o;
    assign pop_eff  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_eff && !pop_eff) cnt_d = cnt_q + CW'(1);
        if (pop_eff && !push_eff) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/grf_wb_writer.sv
// Sole driver of the GRF write port: merges the W-stage result with buffered
// long-latency results and tracks in-flight long-latency destinations.
module grf_wb_writer
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = WB_DW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              w_valid,
    input  logic [4:0]        w_wa,
    input  logic [DW-1:0]     w_data,
    input  logic [DW-1:0]     w_pc,
    input  logic              lr_valid,
    output logic              lr_ready,
    input  logic [4:0]        lr_wa,
    input  logic [DW-1:0]     lr_data,
    input  logic [DW-1:0]     lr_pc,
    input  logic              iss_valid,
    input  logic [4:0]        iss_wa,
    output logic              RegWrite,
    output logic [4:0]        WA,
    output logic [DW-1:0]     RegData,
    output logic [DW-1:0]     PC_Out,
    output logic [NREGS-1:0]  pend_vec,
    output logic [CW-1:0]     fifo_cnt
);

    // The buffered entry type is fixed to the package data width.
    if (DW != WB_DW) begin : g_dw_check
        $error("grf_wb_writer: DW must equal grf_wb_pkg::WB_DW");
    end

    wb_src_t          sel;
    wb_entry_t        sel_e, lr_e, head_e;
    logic             fifo_full, fifo_empty, push, pop;

    logic             regwrite_q, regwrite_d;
    logic [4:0]       wa_q, wa_d;
    logic [DW-1:0]    data_q, data_d;
    logic [DW-1:0]    pc_q, pc_d;
    logic [NREGS-1:0] pend_q, pend_d;

    assign lr_e     = '{wa: lr_wa, data: lr_data, pc: lr_pc};
    assign lr_ready = (fifo_cnt < CW'(DEPTH));

    always_comb begin
        sel   = SRC_NONE;
        sel_e = '0;
        if (w_valid) begin
            sel   = SRC_W;
            sel_e = '{wa: w_wa, data: w_data, pc: w_pc};
        end else if (!fifo_empty) begin
            sel   = SRC_FIFO;
            sel_e = head_e;
        end else if (lr_valid) begin
            sel   = SRC_BYP;
            sel_e = lr_e;
        end
    end

    // lr_ready uses the pre-pop count, so a full FIFO never sees a push.
    assign push = lr_valid & lr_ready & (sel != SRC_BYP);
    assign pop  = (sel == SRC_FIFO);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (push),
        .push_data_i (lr_e),
        .pop_i       (pop),
        .head_o      (head_e),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        regwrite_d = 1'b0;
        wa_d       = wa_q;
        data_d     = data_q;
        pc_d       = pc_q;
        if (sel != SRC_NONE) begin
            regwrite_d = (sel_e.wa != REG_ZERO);
            wa_d       = sel_e.wa;
            data_d     = sel_e.data;
            pc_d       = sel_e.pc;
        end
    end

    // Clear before set so an issue to the same register in the same cycle wins.
    always_comb begin
        pend_d = pend_q;
        if (sel == SRC_FIFO || sel == SRC_BYP) pend_d = pend_d & ~reg_onehot(sel_e.wa);
        if (iss_valid)                         pend_d = pend_d | reg_onehot(iss_wa);
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            data_q     <= '0;
            pc_q       <= '0;
            pend_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wa_q       <= wa_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign WA       = wa_q;
    assign RegData  = data_q;
    assign PC_Out   = pc_q;
    assign pend_vec = pend_q;

endmodule
